// File: rtl/conso_dyn_acc_multi.sv
// Multi-channel dynamic-energy accumulator: per-channel edge counters feed a
// capacitance-weighted sum that is scaled by a VDD^2 code at finalize.

module conso_dyn_ch #(
  parameter int CNT_W     = 16,
  parameter int EDGE_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             cap_en,
  input  logic             cnt_en,
  input  logic             node,
  output logic             hit,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic prev;

  assign hit = cnt_en & ((EDGE_MODE != 0) ? (node ^ prev) : (node & ~prev));
  assign sat = hit & (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
      cnt  <= '0;
    end else begin
      if (cap_en | cnt_en) prev <= node;
      if (clr)              cnt <= '0;
      else if (hit && !sat) cnt <= cnt + 1'b1;
    end
  end
endmodule

module conso_dyn_acc_multi #(
  parameter int N_CH      = 8,
  parameter int CAP_W     = 8,
  parameter int ACC_W     = 24,
  parameter int CNT_W     = 16,
  parameter int VSQ_W     = 12,
  parameter int VSQ_CODE  = 1089,
  parameter int EDGE_MODE = 0,
  localparam int SEL_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_tick,
  input  logic                    stop_tick,
  input  logic                    fin_test,
  input  logic [N_CH-1:0]         node_in,
  input  logic [N_CH*CAP_W-1:0]   cap_val,
  input  logic [SEL_W-1:0]        ch_sel,
  output logic [ACC_W+VSQ_W-1:0]  internal_energy,
  output logic                    energy_valid,
  output logic [CNT_W-1:0]        ch_toggles,
  output logic                    busy,
  output logic                    overflow
);
  localparam int SUM_W = CAP_W + $clog2(N_CH + 1);
  localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam int EW    = ACC_W + VSQ_W;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [VSQ_W-1:0] VSQ     = VSQ_W'(VSQ_CODE);

  typedef enum logic [2:0] {IDLE, ARMED, MEASURE, HOLD, FINAL, DONE} state_t;
  state_t state, state_nxt;

  logic                        clr, cnt_en;
  logic [N_CH-1:0]             hit, lane_sat;
  logic [N_CH-1:0][CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]            acc;
  logic [SUM_W-1:0]            cap_sum;
  logic [EXT_W-1:0]            acc_ext;
  logic                        acc_sat;

  // A start outside ARMED restarts the window; it outranks any count this cycle.
  assign clr    = start_tick && (state != ARMED);
  assign cnt_en = (state == MEASURE) && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) state_nxt = ARMED;
    else begin
      case (state)
        ARMED:   state_nxt = MEASURE;
        MEASURE: if (fin_test) state_nxt = FINAL;
                 else if (stop_tick) state_nxt = HOLD;
        HOLD:    if (fin_test) state_nxt = FINAL;
        FINAL:   state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      conso_dyn_ch #(.CNT_W(CNT_W), .EDGE_MODE(EDGE_MODE)) u_ch (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .cap_en (state == ARMED),
        .cnt_en (cnt_en),
        .node   (node_in[g]),
        .hit    (hit[g]),
        .cnt    (cnt[g]),
        .sat    (lane_sat[g])
      );
    end
  endgenerate

  // Extended-width add so a wrap can be detected and clamped in one cycle.
  always_comb begin
    cap_sum = '0;
    for (int i = 0; i < N_CH; i++)
      if (hit[i]) cap_sum = cap_sum + SUM_W'(cap_val[i*CAP_W +: CAP_W]);
    acc_ext = EXT_W'(acc) + EXT_W'(cap_sum);
    acc_sat = acc_ext > EXT_W'(ACC_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc             <= '0;
      overflow        <= 1'b0;
      internal_energy <= '0;
      energy_valid    <= 1'b0;
    end else if (clr) begin
      acc          <= '0;
      overflow     <= 1'b0;
      energy_valid <= 1'b0;
    end else begin
      if (state == MEASURE) acc <= acc_sat ? ACC_MAX : acc_ext[ACC_W-1:0];
      if (acc_sat || (|lane_sat)) overflow <= 1'b1;
      if (state == FINAL) begin
        internal_energy <= EW'(acc) * EW'(VSQ);
        energy_valid    <= 1'b1;
      end
    end
  end

  assign busy       = (state == ARMED) || (state == MEASURE) || (state == HOLD) || (state == FINAL);
  assign ch_toggles = (int'(ch_sel) < N_CH) ? cnt[ch_sel] : '0;
endmodule
